// File: rtl/rgb_timing_detect.sv
// Receive-side timing recovery for a parallel RGB stream: pixel coordinates,
// frame-start pulse, measured frame geometry and a geometry-stable lock flag.
module rgb_timing_detect #(
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter logic [3:0]  LOCK_FRAMES = 4'd2,
  parameter logic [11:0] TIMEOUT     = 12'd4000
) (
  input  logic        rgb_clk,
  input  logic        rgb_rst_n,
  input  logic        rgb_hs,
  input  logic        rgb_vs,
  input  logic        rgb_de,
  output logic        pix_valid,
  output logic [10:0] rgb_x,
  output logic [10:0] rgb_y,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked
);

  typedef enum logic [1:0] {ST_UNLOCKED = 2'd0, ST_ARMED = 2'd1, ST_LOCKED = 2'd2} state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  state_t      state_r;
  logic        hs_s1_r, hs_s2_r, vs_s1_r, vs_s2_r, de_s1_r, de_s2_r;
  logic [11:0] hc_r, line_len_r, run_r, line_act_r, hs_cnt_r, de_lines_r;
  logic [3:0]  match_cnt_r;

  logic        hs_edge_s, vs_edge_s, de_rise_s, de_fall_s, timeout_s;
  logic        tuple_eq_s, tuple_nz_s;
  logic [11:0] line_len_next_s, line_act_next_s, hs_cnt_next_s, de_lines_next_s;
  logic [3:0]  match_inc_s;

  // Edge detection and the values the frame counters will hold after this cycle
  always_comb begin
    hs_edge_s = (hs_s1_r == HS_POL) && (hs_s2_r != HS_POL);
    vs_edge_s = (vs_s1_r == VS_POL) && (vs_s2_r != VS_POL);
    de_rise_s = de_s1_r && !de_s2_r;
    de_fall_s = !de_s1_r && de_s2_r;
    timeout_s = (hc_r == TIMEOUT);
    if (hs_edge_s) begin
      line_len_next_s = sat_inc12(hc_r);
      hs_cnt_next_s   = sat_inc12(hs_cnt_r);
    end else begin
      line_len_next_s = line_len_r;
      hs_cnt_next_s   = hs_cnt_r;
    end
    if (de_fall_s) begin
      line_act_next_s = run_r;
      de_lines_next_s = sat_inc12(de_lines_r);
    end else begin
      line_act_next_s = line_act_r;
      de_lines_next_s = de_lines_r;
    end
    tuple_eq_s  = (line_len_next_s == h_total) && (line_act_next_s == h_active) &&
                  (hs_cnt_next_s == v_total) && (de_lines_next_s == v_active);
    tuple_nz_s  = (line_len_next_s != 12'd0) && (line_act_next_s != 12'd0) &&
                  (hs_cnt_next_s != 12'd0) && (de_lines_next_s != 12'd0);
    match_inc_s = (match_cnt_r == 4'hF) ? match_cnt_r : match_cnt_r + 4'd1;
  end

  // Input register stage plus one delayed copy for transition detection;
  // sync history resets to the pulse level so no edge is seen out of reset
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      hs_s1_r <= HS_POL;
      hs_s2_r <= HS_POL;
      vs_s1_r <= VS_POL;
      vs_s2_r <= VS_POL;
      de_s1_r <= 1'b0;
      de_s2_r <= 1'b0;
    end else begin
      hs_s1_r <= rgb_hs;
      hs_s2_r <= hs_s1_r;
      vs_s1_r <= rgb_vs;
      vs_s2_r <= vs_s1_r;
      de_s1_r <= rgb_de;
      de_s2_r <= de_s1_r;
    end
  end

  // Pixel coordinate outputs and frame-start pulse
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      rgb_x       <= 11'd0;
      rgb_y       <= 11'd0;
    end else begin
      pix_valid   <= de_s1_r;
      frame_start <= vs_edge_s;
      if (de_s1_r) begin
        rgb_x <= de_rise_s ? 11'd0 : sat_inc11(rgb_x);
      end else begin
        rgb_x <= rgb_x;
      end
      if (vs_edge_s) begin
        rgb_y <= 11'd0;
      end else if (de_fall_s) begin
        rgb_y <= sat_inc11(rgb_y);
      end else begin
        rgb_y <= rgb_y;
      end
    end
  end

  // Per-line measurement and per-frame line counters (cleared after publish)
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      hc_r       <= 12'd0;
      line_len_r <= 12'd0;
      run_r      <= 12'd0;
      line_act_r <= 12'd0;
      hs_cnt_r   <= 12'd0;
      de_lines_r <= 12'd0;
    end else begin
      hc_r       <= hs_edge_s ? 12'd0 : sat_inc12(hc_r);
      line_len_r <= line_len_next_s;
      line_act_r <= line_act_next_s;
      if (de_rise_s) begin
        run_r <= 12'd1;
      end else if (de_s1_r) begin
        run_r <= sat_inc12(run_r);
      end else begin
        run_r <= run_r;
      end
      hs_cnt_r   <= vs_edge_s ? 12'd0 : hs_cnt_next_s;
      de_lines_r <= vs_edge_s ? 12'd0 : de_lines_next_s;
    end
  end

  // Lock FSM with published geometry; timeout overrides any vs edge
  always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
    if (!rgb_rst_n) begin
      state_r     <= ST_UNLOCKED;
      match_cnt_r <= 4'd0;
      locked      <= 1'b0;
      h_total     <= 12'd0;
      h_active    <= 12'd0;
      v_total     <= 12'd0;
      v_active    <= 12'd0;
    end else if (timeout_s) begin
      state_r     <= ST_UNLOCKED;
      match_cnt_r <= 4'd0;
      locked      <= 1'b0;
    end else if (vs_edge_s) begin
      case (state_r)
        ST_UNLOCKED: begin
          state_r     <= ST_ARMED;
          match_cnt_r <= 4'd0;
          locked      <= 1'b0;
        end
        ST_ARMED, ST_LOCKED: begin
          h_total  <= line_len_next_s;
          h_active <= line_act_next_s;
          v_total  <= hs_cnt_next_s;
          v_active <= de_lines_next_s;
          if (tuple_eq_s && tuple_nz_s) begin
            match_cnt_r <= match_inc_s;
            if (state_r == ST_LOCKED || match_inc_s >= LOCK_FRAMES) begin
              state_r <= ST_LOCKED;
              locked  <= 1'b1;
            end else begin
              state_r <= ST_ARMED;
              locked  <= 1'b0;
            end
          end else begin
            state_r     <= ST_ARMED;
            match_cnt_r <= 4'd0;
            locked      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_UNLOCKED;
          match_cnt_r <= 4'd0;
          locked      <= 1'b0;
        end
      endcase
    end else begin
      state_r     <= state_r;
      match_cnt_r <= match_cnt_r;
      locked      <= locked;
    end
  end

endmodule

// File: tb/tb_rgb_timing_detect.sv
// Directed bench: a scaled-down timing (H 16/2/3/3, V 6/1/2/2) drives a
// default-polarity instance and an inverted-sync instance in parallel.
module tb_rgb_timing_detect;
  localparam int HSW = 3, HBP = 3, HACT = 16;
  localparam int VSW = 2, VBP = 2, VACT = 6, VFP = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic hs_n, vs_n;
  assign hs_n = ~hs;
  assign vs_n = ~vs;

  logic        a_pv, a_fs, a_locked, b_pv, b_fs, b_locked;
  logic [10:0] a_x, a_y, b_x, b_y;
  logic [11:0] a_ht, a_ha, a_vt, a_va, b_ht, b_ha, b_vt, b_va;

  always #5 clk = ~clk;

  rgb_timing_detect dut_a (
    .rgb_clk(clk), .rgb_rst_n(rst_n), .rgb_hs(hs), .rgb_vs(vs), .rgb_de(de),
    .pix_valid(a_pv), .rgb_x(a_x), .rgb_y(a_y), .frame_start(a_fs),
    .h_total(a_ht), .h_active(a_ha), .v_total(a_vt), .v_active(a_va), .locked(a_locked)
  );

  rgb_timing_detect #(.HS_POL(1'b1), .VS_POL(1'b1)) dut_b (
    .rgb_clk(clk), .rgb_rst_n(rst_n), .rgb_hs(hs_n), .rgb_vs(vs_n), .rgb_de(de),
    .pix_valid(b_pv), .rgb_x(b_x), .rgb_y(b_y), .frame_start(b_fs),
    .h_total(b_ht), .h_active(b_ha), .v_total(b_vt), .v_active(b_va), .locked(b_locked)
  );

  int total = 0, passed = 0;
  int cyc = 0, last_hs_cyc = 0, fall_cyc = 0;
  int fs_cnt = 0, b_fs_cnt = 0, rise_fs = 0, b_rise_fs = 0, fall_fs = 0;
  int pv_cnt = 0, lag_err = 0;
  logic rise_with_fs = 1'b0, fall_with_fs = 1'b0, pv_seen = 1'b0, lag_on = 1'b0;
  logic a_lk_prev = 1'b0, b_lk_prev = 1'b0, d1 = 1'b0, d2 = 1'b0;
  logic [10:0] first_x, first_y, last_x, last_y;

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic h, input logic v, input logic d);
    @(negedge clk);
    cyc++;
    if (lag_on && a_pv !== d2) lag_err++;
    if (a_pv === 1'b1) begin
      pv_cnt++;
      if (!pv_seen) begin
        first_x = a_x;
        first_y = a_y;
        pv_seen = 1'b1;
      end
      last_x = a_x;
      last_y = a_y;
    end
    if (a_fs === 1'b1) fs_cnt++;
    if (b_fs === 1'b1) b_fs_cnt++;
    if (a_locked === 1'b1 && !a_lk_prev) begin
      rise_fs = fs_cnt;
      rise_with_fs = a_fs;
    end
    if (a_locked === 1'b0 && a_lk_prev) begin
      fall_fs = fs_cnt;
      fall_with_fs = a_fs;
      fall_cyc = cyc;
    end
    if (b_locked === 1'b1 && !b_lk_prev) b_rise_fs = b_fs_cnt;
    a_lk_prev = a_locked;
    b_lk_prev = b_locked;
    if (hs && !h) last_hs_cyc = cyc;
    d2 = d1;
    d1 = d;
    hs = h;
    vs = v;
    de = d;
  endtask

  task automatic send_line(input logic v, input logic act, input int hfp);
    for (int i = 0; i < HSW; i++) step(1'b0, v, 1'b0);
    for (int i = 0; i < HBP; i++) step(1'b1, v, 1'b0);
    for (int i = 0; i < HACT; i++) step(1'b1, v, act);
    for (int i = 0; i < hfp; i++) step(1'b1, v, 1'b0);
  endtask

  task automatic send_frame(input int hfp);
    for (int l = 0; l < VSW; l++) send_line(1'b0, 1'b0, hfp);
    for (int l = 0; l < VBP; l++) send_line(1'b1, 1'b0, hfp);
    for (int l = 0; l < VACT; l++) send_line(1'b1, 1'b1, hfp);
    for (int l = 0; l < VFP; l++) send_line(1'b1, 1'b0, hfp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (a_pv !== 1'b0) $display("FAIL reset_pix_valid: got %b want 0", a_pv); else passed++;
    total++; if (a_x !== 11'd0) $display("FAIL reset_x: got %0d want 0", a_x); else passed++;
    total++; if (a_y !== 11'd0) $display("FAIL reset_y: got %0d want 0", a_y); else passed++;
    total++; if (a_fs !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", a_fs); else passed++;
    total++; if (a_ht !== 12'd0) $display("FAIL reset_h_total: got %0d want 0", a_ht); else passed++;
    total++; if (a_ha !== 12'd0) $display("FAIL reset_h_active: got %0d want 0", a_ha); else passed++;
    total++; if (a_vt !== 12'd0) $display("FAIL reset_v_total: got %0d want 0", a_vt); else passed++;
    total++; if (a_va !== 12'd0) $display("FAIL reset_v_active: got %0d want 0", a_va); else passed++;
    total++; if (a_locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", a_locked); else passed++;
    rst_n = 1'b1;
  endtask

  // Six steady frames: lock appears with the 4th frame_start pulse.
  task automatic test_lock;
    lag_on = 1'b1;
    idle(4);
    for (int f = 0; f < 6; f++) send_frame(2);
    total++; if (rise_fs != 4) $display("FAIL lock_edge: got %0d want 4", rise_fs); else passed++;
    total++; if (rise_with_fs !== 1'b1) $display("FAIL lock_timing: got %b want 1", rise_with_fs); else passed++;
    total++; if (a_ht !== 12'd24) $display("FAIL lock_h_total: got %0d want 24", a_ht); else passed++;
    total++; if (a_ha !== 12'd16) $display("FAIL lock_h_active: got %0d want 16", a_ha); else passed++;
    total++; if (a_vt !== 12'd11) $display("FAIL lock_v_total: got %0d want 11", a_vt); else passed++;
    total++; if (a_va !== 12'd6) $display("FAIL lock_v_active: got %0d want 6", a_va); else passed++;
    total++; if (b_rise_fs != 4) $display("FAIL pol_lock_edge: got %0d want 4", b_rise_fs); else passed++;
    total++; if (b_ht !== 12'd24) $display("FAIL pol_h_total: got %0d want 24", b_ht); else passed++;
    total++; if (b_vt !== 12'd11) $display("FAIL pol_v_total: got %0d want 11", b_vt); else passed++;
    total++; if (b_va !== 12'd6) $display("FAIL pol_v_active: got %0d want 6", b_va); else passed++;
  endtask

  task automatic test_pixels;
    pv_cnt = 0;
    pv_seen = 1'b0;
    send_frame(2);
    total++; if (pv_cnt != 96) $display("FAIL pix_count: got %0d want 96", pv_cnt); else passed++;
    total++; if (first_x !== 11'd0 || first_y !== 11'd0) $display("FAIL pix_first: got %0d,%0d want 0,0", first_x, first_y); else passed++;
    total++; if (last_x !== 11'd15 || last_y !== 11'd5) $display("FAIL pix_last: got %0d,%0d want 15,5", last_x, last_y); else passed++;
    total++; if (lag_err != 0) $display("FAIL pix_lag: got %0d late/early cycles want 0", lag_err); else passed++;
    lag_on = 1'b0;
  endtask

  // Front porch grows by one clock from a frame boundary onward.
  task automatic test_hfp_change;
    fs_cnt = 0;
    rise_fs = 0;
    fall_fs = 0;
    fall_with_fs = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(3);
    total++; if (fall_fs != 2) $display("FAIL unlock_edge: got %0d want 2", fall_fs); else passed++;
    total++; if (fall_with_fs !== 1'b1) $display("FAIL unlock_timing: got %b want 1", fall_with_fs); else passed++;
    total++; if (rise_fs != 4) $display("FAIL relock_edge: got %0d want 4", rise_fs); else passed++;
    total++; if (a_ht !== 12'd25) $display("FAIL relock_h_total: got %0d want 25", a_ht); else passed++;
  endtask

  // Idle input: hc clears two clocks after the last driven hs fall, reaches
  // 4000 after 4000 more clocks, and locked drops on the following clock.
  task automatic test_timeout;
    fall_cyc = 0;
    idle(4010);
    total++; if (fall_cyc - last_hs_cyc != 4003) $display("FAIL timeout_delay: got %0d want 4003", fall_cyc - last_hs_cyc); else passed++;
    total++; if (a_locked !== 1'b0) $display("FAIL timeout_locked: got %b want 0", a_locked); else passed++;
    total++; if (a_ht !== 12'd25 || a_vt !== 12'd11) $display("FAIL timeout_hold: got %0d,%0d want 25,11", a_ht, a_vt); else passed++;
  endtask

  task automatic test_midframe_reset;
    send_frame(2);
    for (int l = 0; l < VSW; l++) send_line(1'b0, 1'b0, 2);
    for (int l = 0; l < VBP; l++) send_line(1'b1, 1'b0, 2);
    for (int i = 0; i < HSW + HBP + 6; i++) step(1'b1, 1'b1, (i >= HSW + HBP) ? 1'b1 : 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_pv !== 1'b0 || a_x !== 11'd0) $display("FAIL areset_pixel: got %b,%0d want 0,0", a_pv, a_x); else passed++;
    total++; if (a_ht !== 12'd0 || a_vt !== 12'd0) $display("FAIL areset_geometry: got %0d,%0d want 0,0", a_ht, a_vt); else passed++;
    total++; if (b_ht !== 12'd0) $display("FAIL areset_pol_h_total: got %0d want 0", b_ht); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    fs_cnt = 0;
    rise_fs = 0;
    a_lk_prev = 1'b0;
    idle(2);
    for (int f = 0; f < 5; f++) send_frame(2);
    total++; if (rise_fs != 4) $display("FAIL reset_relock_edge: got %0d want 4", rise_fs); else passed++;
    total++; if (a_ht !== 12'd24 || a_va !== 12'd6) $display("FAIL reset_relock_geometry: got %0d,%0d want 24,6", a_ht, a_va); else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_hfp_change();
    test_timeout();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
